// File: rtl/baud_pkg.sv
// Shared widths, divisor type and reset-divisor helper for the fractional baud generator.
package baud_pkg;
  localparam int DIV_INT_W_DEF  = 16;
  localparam int DIV_FRAC_W_DEF = 4;
  localparam int DIV_W_DEF      = DIV_INT_W_DEF + DIV_FRAC_W_DEF;

  typedef logic [DIV_W_DEF-1:0] div_word_t;

  localparam div_word_t ONE_DIV = div_word_t'(2 ** DIV_FRAC_W_DEF);

  // round(clk * 2^F / (baud * oversample)) in 2^-F clock units
  function automatic longint calc_default_div(input longint clk_freq, input longint baud,
                                              input longint oversample, input int frac_w);
    longint den;
    den = baud * oversample;
    return ((clk_freq << frac_w) + (den / 64'sd2)) / den;
  endfunction
endpackage

// File: rtl/baud_frac_acc.sv
// Fractional-N phase accumulator: adds 1.0 per enabled cycle, subtracts the clamped divisor on wrap.
module baud_frac_acc #(
  parameter int DIV_W  = 20,
  parameter int FRAC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [DIV_W-1:0] div,
  output logic             hit
);
  localparam int ACC_W = DIV_W + 1;
  localparam logic [ACC_W-1:0] ONE_A = ACC_W'(1) << FRAC_W;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] nxt_s, eff_div_s;

  // Clamp divisor to 1.0 and compute next phase; sync wins over accumulation
  always_comb begin
    hit   = 1'b0;
    acc_d = acc_q;
    nxt_s = acc_q + ONE_A;
    if ({1'b0, div} < ONE_A) begin
      eff_div_s = ONE_A;
    end else begin
      eff_div_s = {1'b0, div};
    end
    if (sync) begin
      acc_d = '0;
    end else if (en) begin
      if (nxt_s >= eff_div_s) begin
        hit   = 1'b1;
        acc_d = nxt_s - eff_div_s;
      end else begin
        acc_d = nxt_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/baud_gen_frac.sv
// Fractional UART baud generator: os/bit/mid ticks with shadowed run-time divisor.
// Optional BAUD_GEN_TICK_CNT_EN adds a 32-bit bit_tick counter port tick_cnt.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_INT_W  = DIV_INT_W_DEF,
  parameter int DIV_FRAC_W = DIV_FRAC_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic                              sync,
  input  logic                              div_wr,
  input  logic [DIV_INT_W+DIV_FRAC_W-1:0]   div_in,
  output logic [DIV_INT_W+DIV_FRAC_W-1:0]   div_q,
  output logic                              os_tick,
  output logic                              bit_tick,
`ifdef BAUD_GEN_TICK_CNT_EN
  output logic                              mid_tick,
  output logic [31:0]                       tick_cnt
`else
  output logic                              mid_tick
`endif
);
  localparam int DIV_W = DIV_INT_W + DIV_FRAC_W;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEFAULT_DIV =
    DIV_W'(calc_default_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE, DIV_FRAC_W));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0] div_d, pend_q, pend_d;
  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d, bit_tick_q, bit_tick_d, mid_tick_q, mid_tick_d;
  logic             hit_s;
`ifdef BAUD_GEN_TICK_CNT_EN
  logic [31:0]      tick_cnt_q, tick_cnt_d;
`endif

  baud_frac_acc #(.DIV_W(DIV_W), .FRAC_W(DIV_FRAC_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sync  (sync),
    .div   (div_q),
    .hit   (hit_s)
  );

  // Divisor shadow: a pending write takes effect at a period boundary or while idle/restarting
  always_comb begin
    if (div_wr) begin
      pend_d = div_in;
    end else begin
      pend_d = pend_q;
    end
    if (sync || !en || hit_s) begin
      div_d = pend_d;
    end else begin
      div_d = div_q;
    end
  end

  // Oversample counter and tick generation
  always_comb begin
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    os_cnt_d   = os_cnt_q;
    if (sync) begin
      os_cnt_d = '0;
    end else if (hit_s) begin
      os_tick_d  = 1'b1;
      bit_tick_d = (os_cnt_q == CNT_LAST);
      mid_tick_d = (os_cnt_q == CNT_MID);
      if (os_cnt_q == CNT_LAST) begin
        os_cnt_d = '0;
      end else begin
        os_cnt_d = os_cnt_q + CNT_W'(1);
      end
    end else begin
      os_cnt_d = os_cnt_q;
    end
  end

`ifdef BAUD_GEN_TICK_CNT_EN
  // bit_tick counter, unaffected by sync
  always_comb begin
    if (hit_s && (os_cnt_q == CNT_LAST)) begin
      tick_cnt_d = tick_cnt_q + 32'd1;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= 32'd0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= DEFAULT_DIV;
      pend_q     <= DEFAULT_DIV;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pend_q     <= pend_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: stimulus queues expected tick cycles, a monitor pops and compares.
module tb_baud_gen_frac;
  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         sync = 1'b0;
  logic         div_wr = 1'b0;
  logic [W-1:0] div_in = 20'd0;
  logic [W-1:0] div_q;
  logic         os_tick, bit_tick, mid_tick;
`ifdef BAUD_GEN_TICK_CNT_EN
  logic [31:0]  tick_cnt;
`endif

  baud_gen_frac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .div_q    (div_q),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
`ifdef BAUD_GEN_TICK_CNT_EN
    .mid_tick (mid_tick),
    .tick_cnt (tick_cnt)
`else
    .mid_tick (mid_tick)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit b;
    bit m;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;
  int   osc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // expected os_tick at absolute edge c; bit/mid flags from the oversample position
  task automatic push_tick(input int c);
    exp_t e;
    e.cyc = c;
    e.b   = (osc == 15);
    e.m   = (osc == 7);
    sb.push_back(e);
    osc = (osc + 1) % 16;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every os_tick must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (os_tick === 1'b1) begin
        if (sb.size() == 0) begin
          ntests++;
          nfail++;
          $display("FAIL unexpected_os_tick: tick at cycle %0d, expected none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          ntests++;
          if (e.cyc != cyc || e.b !== bit_tick || e.m !== mid_tick) begin
            nfail++;
            $display("FAIL os_tick_event: got cycle %0d bit %b mid %b, expected cycle %0d bit %b mid %b",
                     cyc, bit_tick, mid_tick, e.cyc, e.b, e.m);
          end
        end
      end else if (bit_tick !== 1'b0 || mid_tick !== 1'b0 || os_tick !== 1'b0) begin
        ntests++;
        nfail++;
        $display("FAIL stray_tick: cycle %0d os %b bit %b mid %b, expected all 0",
                 cyc, os_tick, bit_tick, mid_tick);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("reset_os_tick", os_tick, 0);
    chk("reset_bit_tick", bit_tick, 0);
    chk("reset_mid_tick", mid_tick, 0);
    chk("reset_div_q", div_q, 434);
    rst_n = 1'b1;

    // default divisor 27.125: 16 ticks in 434 cycles
    @(negedge clk);
    c = cyc;
    en = 1'b1;
    for (int k = 1; k <= 16; k++) push_tick(c + (434 * k + 15) / 16);
    repeat (434) @(negedge clk);
    en = 1'b0;

    // divisor 5.0 written while disabled applies at once
    div_wr = 1'b1;
    div_in = 20'd80;
    @(negedge clk);
    div_wr = 1'b0;
    chk("div_q_80", div_q, 80);
    c = cyc;
    en = 1'b1;
    for (int k = 1; k <= 20; k++) push_tick(c + 5 * k);
    repeat (100) @(negedge clk);
    en = 1'b0;

    // 80 -> 160 mid-period: current period completes at 5, then 10
    @(negedge clk);
    c = cyc;
    en = 1'b1;
    push_tick(c + 5);
    push_tick(c + 10);
    push_tick(c + 15);
    push_tick(c + 25);
    push_tick(c + 35);
    push_tick(c + 45);
    repeat (12) @(negedge clk);
    div_wr = 1'b1;
    div_in = 20'd160;
    @(negedge clk);
    div_wr = 1'b0;
    repeat (32) @(negedge clk);
    en = 1'b0;
    chk("div_q_160", div_q, 160);

    // clamp: 0.5 and 0.0 both behave as 1.0
    div_wr = 1'b1;
    div_in = 20'd8;
    sync = 1'b1;
    @(negedge clk);
    div_wr = 1'b0;
    sync = 1'b0;
    osc = 0;
    chk("div_q_8", div_q, 8);
    c = cyc;
    en = 1'b1;
    for (int k = 1; k <= 32; k++) push_tick(c + k);
    repeat (32) @(negedge clk);
    en = 1'b0;

    div_wr = 1'b1;
    div_in = 20'd0;
    sync = 1'b1;
    @(negedge clk);
    div_wr = 1'b0;
    sync = 1'b0;
    osc = 0;
    chk("div_q_0", div_q, 0);
    c = cyc;
    en = 1'b1;
    for (int k = 1; k <= 16; k++) push_tick(c + k);
    repeat (16) @(negedge clk);
    en = 1'b0;

    // sync at os_cnt=9, then en low for 7 cycles
    div_wr = 1'b1;
    div_in = 20'd80;
    sync = 1'b1;
    @(negedge clk);
    div_wr = 1'b0;
    sync = 1'b0;
    osc = 0;
    chk("div_q_80_again", div_q, 80);
    c = cyc;
    en = 1'b1;
    for (int k = 1; k <= 9; k++) push_tick(c + 5 * k);
    osc = 0;
    for (int k = 1; k <= 16; k++) push_tick(c + 48 + 5 * k);
    push_tick(c + 140);
    push_tick(c + 145);
    push_tick(c + 150);
    repeat (47) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    repeat (82) @(negedge clk);
    en = 1'b0;
    repeat (7) @(negedge clk);
    en = 1'b1;
    repeat (13) @(negedge clk);
    en = 1'b0;

    // asynchronous reset while os_tick is high
    @(negedge clk);
    c = cyc;
    en = 1'b1;
    push_tick(c + 5);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_os_tick", os_tick, 0);
    chk("async_rst_bit_tick", bit_tick, 0);
    chk("async_rst_mid_tick", mid_tick, 0);
    chk("async_rst_div_q", div_q, 434);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    osc = 0;
`ifdef BAUD_GEN_TICK_CNT_EN
    chk("tick_cnt_reset", tick_cnt, 0);
`endif
    div_wr = 1'b1;
    div_in = 20'd8;
    @(negedge clk);
    div_wr = 1'b0;
    c = cyc;
    en = 1'b1;
    for (int k = 1; k <= 32; k++) push_tick(c + k);
    repeat (32) @(negedge clk);
    en = 1'b0;
`ifdef BAUD_GEN_TICK_CNT_EN
    chk("tick_cnt_two", tick_cnt, 2);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
